fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Read-side consumer placed directly downstream of synchronous_fifo.
- Drains the FIFO's byte stream through its rd_en/empty interface and packs PACK_RATIO consecutive bytes, little-endian, into one wide word.
- Presents each packed word on a valid/ready master port.
- A flush request emits any partial word with a byte-keep mask and a last marker, so the downstream bus interface never waits on a stale tail.

Parameters:
- DATA_WIDTH, 8: FIFO byte width; must match synchronous_fifo.
- PACK_RATIO, 4: bytes per output word; power of two, 2..8.
- OUT_WIDTH, DATA_WIDTH*PACK_RATIO: output word width; derived, do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  empty flag from synchronous_fifo.
- fifo_data  in  DATA_WIDTH  data_out of synchronous_fifo; valid in the cycle after an accepted rd_en.
- fifo_rd_en  out  1  read strobe to synchronous_fifo.
- flush  in  1  single-cycle request to emit the current partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  OUT_WIDTH  packed word; first byte read is in bits [DATA_WIDTH-1:0].
- m_keep  out  PACK_RATIO  per-byte valid mask.
- m_last  out  1  word was produced by a flush.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
Reset
- Clock is clk; reset is synchronous and active-high.
- While reset is high, at each edge: fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0, state=COLLECT, byte counters=0.
- Reset mid-operation discards the partial word, the output word and any in-flight read. A byte landing after reset is ignored.

FIFO read timing (decided)
- fifo_data for a read issued in cycle N is valid in cycle N+1. The packer captures it at the end of cycle N+1.
- rd_pending register tracks the in-flight read.

Storage
- Assembly register: PACK_RATIO byte slots.
- resv_cnt = captured bytes + rd_pending.
- Output register: m_data/m_keep/m_last/m_valid.

Read issue
- fifo_rd_en = !fifo_empty && state==COLLECT && resv_cnt < PACK_RATIO.
- Combinational from registered state and fifo_empty; no read is ever issued when fifo_empty=1.
- Steady-state throughput: one byte per cycle.

Word completion
- When the byte filling slot PACK_RATIO-1 lands, the packer loads the output register at that edge if it is empty or being accepted (m_valid && m_ready), and clears the assembly register.
- Otherwise the completed word waits in the assembly register and reads stall (resv_cnt = PACK_RATIO).
- Latency: first rd_en in cycle 0 with no stalls gives m_valid=1 in cycle PACK_RATIO+1.
- m_keep is all ones and m_last=0 for full words.

Output handshake
- A transfer occurs when m_valid && m_ready at a rising edge.
- m_data/m_keep/m_last are held stable while m_valid=1 && m_ready=0.
- Back-to-back words are supported with no bubble.

State machine
- COLLECT: normal operation. flush=1 moves to FLUSH_WAIT.
- FLUSH_WAIT: no new reads. Waits until rd_pending=0 and the output register is free.
  - With 0 bytes captured: pulse flush_done and return to COLLECT; no word is emitted.
  - With k bytes captured: load the output register with m_keep low k bits set, m_last=1, unused bytes zero; go to FLUSH_EMIT.
- FLUSH_EMIT: on output transfer, pulse flush_done and return to COLLECT.

Boundary conditions
- If a full word completes in the same cycle flush is seen, the full word is emitted normally (m_last=0). The flush then applies to an empty assembly register: flush_done pulses and no extra word is emitted.
- flush asserted while not in COLLECT is ignored.
- fifo_empty rising while a read is pending does not cancel that read's data.
- Max outstanding FIFO reads: 1.

Decomposition:
- Package fifo_pkg:
  - DATA_WIDTH default.
  - typedef packer_state_e {COLLECT, FLUSH_WAIT, FLUSH_EMIT}.
  - Function keep_mask(k) returning a PACK_RATIO-bit mask.
- Single module; no sub-module is needed.
- The bench instantiates synchronous_fifo (FIFO_DEPTH=32, DATA_WIDTH=8) feeding fifo_word_packer.

Test Plan:
1. Reset, write 8 bytes 01..08, m_ready=1 → two words 0x04030201 then 0x08070605; m_keep=4'hF and m_last=0 for both; the first m_valid comes 5 cycles after the first fifo_rd_en.
2. Write 32 bytes (FIFO full), hold m_ready=0 for 20 cycles → exactly 8 bytes are read and fifo_rd_en stays 0 thereafter. Releasing m_ready yields 8 words in byte order with no bubbles.
3. Write 3 bytes AA BB CC, then flush → m_data=0x00CCBBAA, m_keep=4'b0111, m_last=1, then a flush_done pulse.
4. Flush on an empty packer → flush_done pulses within 2 cycles and m_valid stays 0.
5. Write 4 bytes; pulse flush in the cycle the 4th byte lands → one word with m_keep=F and m_last=0, flush_done pulses, no second word.
6. Assert reset with 2 bytes captured and a word held (m_ready=0) → all outputs 0 next cycle. Writing 4 new bytes after reset yields only the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAX_RATIO  = 8;

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH_WAIT,
    FLUSH_EMIT
  } packer_state_e;

  // Low k bits set; callers truncate to their own PACK_RATIO.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int k);
    logic [MAX_RATIO-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_RATIO; i++) mask[i] = (i < k);
    return mask;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Packed-word valid/ready stream leaving the packer.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PACK_RATIO = 4
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;

  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_WIDTH-1:0]  m_data;
  logic [PACK_RATIO-1:0] m_keep;
  logic                  m_last;

  modport master (output m_valid, m_data, m_keep, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_keep, m_last, output m_ready);
endinterface

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO; data_out is registered and valid the cycle after an accepted rd_en.
module synchronous_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok, rd_ok;

  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs PACK_RATIO bytes little-endian into words;
// flush emits the partial tail with a keep mask and last marker.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int PACK_RATIO = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * PACK_RATIO
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  flush_done,
  fifo_word_packer_if.master    m
);
  localparam int            CW   = $clog2(PACK_RATIO + 1);
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);
  localparam logic [CW-1:0] LAST = CW'(PACK_RATIO - 1);

  typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] word_t;

  packer_state_e state;
  word_t         asm_q, word_full, word_part;
  logic [CW-1:0] cap_cnt, resv_cnt;
  logic          rd_pending, out_free, full_avail;

  // Reserve a slot for the in-flight byte so at most one word's worth is ever claimed.
  assign resv_cnt   = cap_cnt + CW'(rd_pending);
  assign fifo_rd_en = !reset && !fifo_empty && state == COLLECT && resv_cnt < FULL;
  assign out_free   = !m.m_valid || m.m_ready;
  assign full_avail = cap_cnt == FULL || (rd_pending && cap_cnt == LAST);

  always_comb begin
    word_full = asm_q;
    word_part = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (rd_pending && cap_cnt == CW'(i)) word_full[i] = fifo_data;
      if (CW'(i) < cap_cnt)                word_part[i] = asm_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      asm_q      <= '0;
      cap_cnt    <= '0;
      rd_pending <= 1'b0;
      flush_done <= 1'b0;
      m.m_valid  <= 1'b0;
      m.m_data   <= '0;
      m.m_keep   <= '0;
      m.m_last   <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      rd_pending <= fifo_rd_en;
      if (m.m_valid && m.m_ready) m.m_valid <= 1'b0;

      // A completed word always leaves before any flush handling sees the assembly register.
      if (full_avail && out_free) begin
        m.m_valid <= 1'b1;
        m.m_data  <= OUT_WIDTH'(word_full);
        m.m_keep  <= '1;
        m.m_last  <= 1'b0;
        asm_q     <= '0;
        cap_cnt   <= '0;
      end else if (rd_pending) begin
        asm_q   <= word_full;
        cap_cnt <= cap_cnt + CW'(1);
      end

      case (state)
        COLLECT: if (flush) state <= FLUSH_WAIT;
        FLUSH_WAIT: begin
          if (!rd_pending && out_free && !full_avail) begin
            if (cap_cnt == '0) begin
              flush_done <= 1'b1;
              state      <= COLLECT;
            end else begin
              m.m_valid <= 1'b1;
              m.m_data  <= OUT_WIDTH'(word_part);
              m.m_keep  <= PACK_RATIO'(keep_mask(int'(cap_cnt)));
              m.m_last  <= 1'b1;
              asm_q     <= '0;
              cap_cnt   <= '0;
              state     <= FLUSH_EMIT;
            end
          end
        end
        FLUSH_EMIT: begin
          if (m.m_valid && m.m_ready) begin
            flush_done <= 1'b1;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// synchronous_fifo feeding fifo_word_packer; directed and random byte streams
// compared against a byte-queue packing model.
module tb_fifo_word_packer;
  localparam int DW = 8, PR = 4, DEPTH = 32;

  logic       clk = 1'b0, reset = 1'b1;
  logic       wr_en = 1'b0, flush = 1'b0;
  logic [7:0] din = '0;
  logic       full, empty, rd_en, flush_done;
  logic [7:0] fifo_data;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) mif ();

  synchronous_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(din), .rd_en(rd_en),
    .data_out(fifo_data), .full(full), .empty(empty)
  );

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk(clk), .reset(reset), .fifo_empty(empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_en), .flush(flush), .flush_done(flush_done), .m(mif)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rd_cnt = 0, fd_cnt = 0, fd_cyc = -1, fl_cyc = -1, rd_first = -1, v_first = -1;
  logic [31:0] w_q[$];
  logic [3:0]  k_q[$];
  logic        l_q[$];
  int          t_q[$];
  logic [7:0]  exp_b[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
      end
      if (mif.m_valid && v_first < 0) v_first = cyc;
      if (mif.m_valid && mif.m_ready) begin
        w_q.push_back(mif.m_data);
        k_q.push_back(mif.m_keep);
        l_q.push_back(mif.m_last);
        t_q.push_back(cyc);
      end
      if (flush_done) begin fd_cnt++; fd_cyc = cyc; end
      if (flush) fl_cyc = cyc;
    end
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1;
    din   = b;
    exp_b.push_back(b);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && w_q.size() < n; i++) @(negedge clk);
    chk("wait_words", w_q.size() >= n, 1);
  endtask

  task automatic clear_q();
    w_q.delete(); k_q.delete(); l_q.delete(); t_q.delete();
  endtask

  // Model: next n bytes of the written stream, first byte in the low lane.
  task automatic expect_word(input string tag, input int n, input logic last);
    logic [31:0] w;
    logic [3:0]  k;
    w = '0; k = '0;
    for (int i = 0; i < n; i++) begin
      w |= 32'(exp_b.pop_front()) << (8 * i);
      k[i] = 1'b1;
    end
    chk({tag, "_present"}, w_q.size() > 0, 1);
    if (w_q.size() > 0) begin
      chk({tag, "_data"}, w_q.pop_front(), w);
      chk({tag, "_keep"}, k_q.pop_front(), k);
      chk({tag, "_last"}, l_q.pop_front(), last);
      void'(t_q.pop_front());
    end
  endtask

  initial begin
    int base, fd0, tx, n, rem, sent;
    logic [7:0] k8;
    mif.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", mif.m_valid, 0);
    chk("rst_data", mif.m_data, 0);
    chk("rst_keep", mif.m_keep, 0);
    chk("rst_last", mif.m_last, 0);
    chk("rst_done", flush_done, 0);
    reset = 1'b0;

    // T1: two full words, first-word latency
    mif.m_ready = 1'b1;
    for (int b = 1; b <= 8; b++) write_byte(8'(b));
    wait_words(2, 60);
    chk("t1_latency", v_first - rd_first, 5);
    expect_word("t1_w0", 4, 1'b0);
    expect_word("t1_w1", 4, 1'b0);

    // T2: backpressure caps reads at two words' worth
    mif.m_ready = 1'b0;
    base = rd_cnt;
    for (int i = 0; i < 32; i++) write_byte(8'($urandom));
    repeat (20) @(negedge clk);
    chk("t2_reads", rd_cnt - base, 8);
    chk("t2_rd_idle", rd_en, 0);
    chk("t2_no_xfer", w_q.size(), 0);
    mif.m_ready = 1'b1;
    wait_words(8, 400);
    if (t_q.size() >= 2) chk("t2_back_to_back", t_q[1] - t_q[0], 1);
    for (int i = 0; i < 8; i++) expect_word("t2_w", 4, 1'b0);

    // T3: partial flush AA BB CC
    write_byte(8'hAA); write_byte(8'hBB); write_byte(8'hCC);
    repeat (10) @(negedge clk);
    fd0 = fd_cnt;
    pulse_flush();
    wait_words(1, 20);
    repeat (5) @(negedge clk);
    tx = (t_q.size() > 0) ? t_q[0] : -100;
    if (w_q.size() > 0) chk("t3_spec_word", w_q[0], 32'h00CCBBAA);
    expect_word("t3", 3, 1'b1);
    chk("t3_done_cnt", fd_cnt - fd0, 1);
    chk("t3_done_after_xfer", fd_cyc - tx, 1);

    // T3b: random partial lengths
    repeat (3) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
      repeat (10) @(negedge clk);
      fd0 = fd_cnt;
      pulse_flush();
      wait_words(1, 20);
      repeat (4) @(negedge clk);
      expect_word("t3b", n, 1'b1);
      chk("t3b_done_cnt", fd_cnt - fd0, 1);
    end

    // T4: flush with nothing collected
    fd0 = fd_cnt;
    pulse_flush();
    repeat (4) @(negedge clk);
    chk("t4_done_cnt", fd_cnt - fd0, 1);
    chk("t4_done_latency", (fd_cyc - fl_cyc) <= 2, 1);
    chk("t4_no_word", w_q.size(), 0);
    chk("t4_valid", mif.m_valid, 0);

    // T5: flush in the cycle the fourth byte lands
    fd0 = fd_cnt;
    base = rd_cnt;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    for (int i = 0; i < 20 && rd_cnt - base < 4; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("t5_reads", rd_cnt - base, 4);
    repeat (8) @(negedge clk);
    expect_word("t5", 4, 1'b0);
    chk("t5_no_second", w_q.size(), 0);
    chk("t5_done_cnt", fd_cnt - fd0, 1);

    // T6: reset with a held word and a partial word
    mif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    repeat (15) @(negedge clk);
    chk("t6_held", mif.m_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_valid", mif.m_valid, 0);
    chk("t6_data", mif.m_data, 0);
    chk("t6_keep", mif.m_keep, 0);
    chk("t6_last", mif.m_last, 0);
    chk("t6_done", flush_done, 0);
    reset = 1'b0;
    exp_b.delete();
    clear_q();
    mif.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    wait_words(1, 30);
    repeat (6) @(negedge clk);
    expect_word("t6", 4, 1'b0);
    chk("t6_only_new", w_q.size(), 0);

    // T7: random stream with random backpressure, tail flushed
    n = $urandom_range(9, 40);
    base = rd_cnt;
    sent = 0;
    fd0 = fd_cnt;
    for (int i = 0; i < 2000 && !(sent == n && rd_cnt - base == n); i++) begin
      @(negedge clk);
      mif.m_ready = 1'($urandom_range(0, 1));
      if (sent < n && !full && $urandom_range(0, 1) == 1) begin
        k8 = 8'($urandom);
        wr_en = 1'b1; din = k8;
        exp_b.push_back(k8);
        sent++;
      end else wr_en = 1'b0;
    end
    @(negedge clk);
    wr_en = 1'b0;
    mif.m_ready = 1'b1;
    chk("t7_reads", rd_cnt - base, n);
    repeat (10) @(negedge clk);
    pulse_flush();
    repeat (20) @(negedge clk);
    rem = n % 4;
    for (int i = 0; i < n / 4; i++) expect_word("t7_full", 4, 1'b0);
    if (rem != 0) expect_word("t7_tail", rem, 1'b1);
    chk("t7_no_extra", w_q.size(), 0);
    chk("t7_done_cnt", fd_cnt - fd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
